nmi_scheduler: RTL and testbench
================================

// Module: nmi_scheduler
// PURPOSE
//  Sequences and shares the Z80 NMI / magic-ROM overlay between several NMI requesters (magic button, expansion, debug).
//  - Latches requests and picks one by fixed priority.
//  - Aligns NMI assertion to the frame INT edge.
//  - Maps the overlay on the M1 fetch at 0x0066.
//  - Unmaps the overlay on a read of the exit address.
//  - Sits between the request sources and the memory-map / CPU NMI pin.
// PARAMETERS
//  NREQ          3        number of requesters, index 0 = highest priority
//  EXIT_ADDR     16'hF000 overlay read address that ends service
//  TIMEOUT_FRMS  4        INT frames to wait for the 0x0066 fetch before abort (1..15)
// PORTS
//  clk28      in   1     system clock; reset is synchronous, active-high
//  rst        in   1     synchronous active-high reset
//  bus        cpu_bus -  CPU bus interface: mreq, m1, rd, a[15:0] used (all registered to clk28)
//  n_int      in   1     current frame INT, active low
//  n_int_next in   1     INT value for the next clk28 cycle
//  req        in   NREQ  NMI requests; rising edge is latched
//  grant      out  NREQ  one-hot owner of the current service, 0 when idle
//  n_nmi      out  1     CPU NMI, active low, registered
//  ovl_map    out  1     magic overlay mapped into CPU address space
//  busy       out  1     state != IDLE
//  abort      out  1     one-cycle pulse: NMI timed out, request dropped
// BEHAVIOUR
//  Reset values: pend=0, state=IDLE, grant=0, n_nmi=1, ovl_map=0, busy=0, abort=0, frame counter=0.
//  Request latching:
//  - pend[i] is set when req[i] is 1 while req_d[i] (the previous-cycle sample) is 0.
//  - pend[i] is cleared on the cycle grant[i] is set; that clear has priority over a new edge only for the granted index.
//  - A new edge on a pend bit that is already set is absorbed (no counting).
//  int_fall = n_int & ~n_int_next.
//  IDLE:
//  - If pend!=0, go to WAIT_INT.
//  WAIT_INT:
//  - On int_fall, load grant with the lowest set pend index (priority taken at that cycle, not earlier).
//  - In the same cycle: clear that pend bit, set n_nmi<=0, frame counter<=0, go to ASSERT.
//  ASSERT:
//  - n_nmi held at 0.
//  - Each int_fall increments the frame counter.
//  - If the counter reaches TIMEOUT_FRMS: n_nmi<=1, grant<=0, abort pulse, go to IDLE (remaining pend bits kept).
//  - If bus.mreq & bus.m1 & bus.a==16'h0066 is true: ovl_map<=1, n_nmi<=1, go to MAPPED.
//  - The fetch takes precedence if it occurs on the same cycle as the timeout.
//  MAPPED:
//  - If bus.mreq & bus.rd & bus.a==EXIT_ADDR is true, go to UNMAP; ovl_map stays 1 so the exit instruction completes from the overlay.
//  UNMAP:
//  - When bus.mreq==0: ovl_map<=0, go to RELEASE.
//  RELEASE:
//  - grant<=0, go to IDLE.
//  - If pend!=0, the next service begins via IDLE->WAIT_INT.
//  Latency:
//  - n_nmi falls 1 clk after the int_fall cycle.
//  - ovl_map rises 1 clk after the 0x0066 fetch is detected.
//  - ovl_map falls 1 clk after the first mreq-low cycle following the exit read.
//  Frame counter: 4 bits, saturating, compared with ==TIMEOUT_FRMS.
//  Requests arriving during a service stay pending; they never preempt the service and never retrigger NMI mid-service.
//  Reset mid-operation: everything returns to reset values on the next clk28; ovl_map drops without waiting for mreq.
//  busy = (state != IDLE); grant stays stable for the whole WAIT_INT..RELEASE window except the WAIT_INT load cycle.
// TESTING
//  1. req[1] pulse, int_fall 100 clk later, fetch 0x0066 -> grant=3'b010 and n_nmi=0 from int_fall+1; ovl_map=1 and n_nmi=1 after fetch+1.
//  2. req[2] and req[0] rise on the same cycle -> req[0] is served first (grant=001); after RELEASE, grant=100 on the next int_fall.
//  3. In MAPPED, read EXIT_ADDR=0xF000 with mreq held 3 clk -> ovl_map stays 1 for those 3 clk, clears 1 clk after mreq=0, grant=0 one clk later.
//  4. No 0x0066 fetch after NMI asserted, 4 int_falls -> abort pulses once, n_nmi=1, grant=0, pend[i]=0 for the dropped request.
//  5. req[0] re-pulses during MAPPED -> no n_nmi change during service; a second NMI is issued on the first int_fall after RELEASE.
//  6. rst asserted in MAPPED with mreq=1 -> next clk: ovl_map=0, n_nmi=1, grant=0, busy=0, pend=0.

Source files
------------

// File: rtl/nmi_scheduler_if.sv
// CPU bus as seen by the NMI scheduler: memory request, M1, read strobe and address.
// Every signal is registered to clk28 before it reaches the scheduler.
interface cpu_bus;
    logic        mreq;
    logic        m1;
    logic        rd;
    logic [15:0] a;

    modport sink   (input  mreq, m1, rd, a);
    modport source (output mreq, m1, rd, a);
endinterface

// File: rtl/nmi_scheduler.sv
// Shares the Z80 NMI and magic-ROM overlay between prioritised requesters.
// NMI is aligned to the frame INT edge; the overlay maps on the 0x0066 fetch and unmaps after the exit read.
//
// state    | meaning
// IDLE     | no service; waits for any pending request
// WAIT_INT | request pending; waits for the INT falling edge to pick the owner
// ASSERT   | n_nmi low; waits for the 0x0066 fetch or a frame timeout
// MAPPED   | overlay mapped; waits for the read of EXIT_ADDR
// UNMAP    | exit read seen; waits for mreq to drop before unmapping
// RELEASE  | drops grant and returns to IDLE
module nmi_scheduler #(
    parameter int          NREQ         = 3,
    parameter logic [15:0] EXIT_ADDR    = 16'hF000,
    parameter int          TIMEOUT_FRMS = 4
) (
    input  logic            clk28,
    input  logic            rst,
    cpu_bus.sink            bus,
    input  logic            n_int,
    input  logic            n_int_next,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            n_nmi,
    output logic            ovl_map,
    output logic            busy,
    output logic            abort
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INT,
        ST_ASSERT,
        ST_MAPPED,
        ST_UNMAP,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT_FRMS);

    state_t          state, state_next;
    logic [NREQ-1:0] pend, pend_next;
    logic [NREQ-1:0] req_d;
    logic [NREQ-1:0] grant_next;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] clr;
    logic [3:0]      frame_cnt, cnt_next, cnt_inc;
    logic            n_nmi_next, ovl_next, abort_next;
    logic            int_fall, fetch_nmi, exit_rd;

    always_ff @(posedge clk28) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend      <= '0;
            req_d     <= '0;
            grant     <= '0;
            n_nmi     <= 1'b1;
            ovl_map   <= 1'b0;
            abort     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            pend      <= pend_next;
            req_d     <= req;
            grant     <= grant_next;
            n_nmi     <= n_nmi_next;
            ovl_map   <= ovl_next;
            abort     <= abort_next;
            frame_cnt <= cnt_next;
        end
    end

    always_comb begin
        int_fall   = n_int & ~n_int_next;
        fetch_nmi  = bus.mreq & bus.m1 & (bus.a == 16'h0066);
        exit_rd    = bus.mreq & bus.rd & (bus.a == EXIT_ADDR);
        // Isolate the lowest set bit: index 0 has the highest priority.
        pick       = pend & (~pend + NREQ'(1));
        cnt_inc    = (int_fall && frame_cnt != 4'hF) ? frame_cnt + 4'd1 : frame_cnt;

        state_next = state;
        grant_next = grant;
        n_nmi_next = n_nmi;
        ovl_next   = ovl_map;
        abort_next = 1'b0;
        cnt_next   = frame_cnt;
        clr        = '0;

        case (state)
            ST_IDLE: begin
                if (|pend) state_next = ST_WAIT_INT;
            end
            ST_WAIT_INT: begin
                if (int_fall && |pend) begin
                    grant_next = pick;
                    clr        = pick;
                    n_nmi_next = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                cnt_next = cnt_inc;
                // A fetch on the timeout cycle still wins: the CPU already took the NMI.
                if (fetch_nmi) begin
                    ovl_next   = 1'b1;
                    n_nmi_next = 1'b1;
                    state_next = ST_MAPPED;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    n_nmi_next = 1'b1;
                    grant_next = '0;
                    abort_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_MAPPED: begin
                if (exit_rd) state_next = ST_UNMAP;
            end
            ST_UNMAP: begin
                if (!bus.mreq) begin
                    ovl_next   = 1'b0;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        pend_next = (pend | (req & ~req_d)) & ~clr;
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_nmi_scheduler.sv
// Directed bench for nmi_scheduler: a per-cycle vector table for the basic service,
// then hand-written sequences for priority, exit hold, timeout, re-request and reset.
module tb_nmi_scheduler;

    logic       clk28;
    logic       rst;
    logic       n_int;
    logic       n_int_next;
    logic [2:0] req;
    logic [2:0] grant;
    logic       n_nmi;
    logic       ovl_map;
    logic       busy;
    logic       abort;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_bus bus_if ();

    nmi_scheduler #(
        .NREQ         (3),
        .EXIT_ADDR    (16'hF000),
        .TIMEOUT_FRMS (4)
    ) dut (
        .clk28      (clk28),
        .rst        (rst),
        .bus        (bus_if),
        .n_int      (n_int),
        .n_int_next (n_int_next),
        .req        (req),
        .grant      (grant),
        .n_nmi      (n_nmi),
        .ovl_map    (ovl_map),
        .busy       (busy),
        .abort      (abort)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        n_int;
        logic        n_int_next;
        logic        mreq;
        logic        m1;
        logic        rd;
        logic [15:0] a;
        logic [2:0]  grant;
        logic        n_nmi;
        logic        ovl;
        logic        busy;
        logic        abort;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] rq, input logic ni, input logic nin,
                       input logic mq, input logic m, input logic rdv, input logic [15:0] addr,
                       input logic [2:0] g, input logic nn, input logic ov, input logic bs,
                       input logic ab);
        vec_t v;
        v.rst = r; v.req = rq; v.n_int = ni; v.n_int_next = nin;
        v.mreq = mq; v.m1 = m; v.rd = rdv; v.a = addr;
        v.grant = g; v.n_nmi = nn; v.ovl = ov; v.busy = bs; v.abort = ab;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] g, input logic nn,
                              input logic ov, input logic bs, input logic ab);
        check({tag, ".grant"},   32'(grant),   32'(g));
        check({tag, ".n_nmi"},   32'(n_nmi),   32'(nn));
        check({tag, ".ovl_map"}, 32'(ovl_map), 32'(ov));
        check({tag, ".busy"},    32'(busy),    32'(bs));
        check({tag, ".abort"},   32'(abort),   32'(ab));
    endtask

    task automatic cyc();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.mreq = 1'b0;
        bus_if.m1   = 1'b0;
        bus_if.rd   = 1'b0;
        bus_if.a    = 16'h0000;
    endtask

    task automatic do_reset();
        req        = '0;
        n_int      = 1'b1;
        n_int_next = 1'b1;
        bus_idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic int_fall();
        n_int_next = 1'b0;
        cyc();
        n_int_next = 1'b1;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        req = r;
        cyc();
        req = '0;
    endtask

    task automatic fetch66();
        bus_if.mreq = 1'b1;
        bus_if.m1   = 1'b1;
        bus_if.a    = 16'h0066;
        cyc();
        bus_idle();
    endtask

    // Exit read held for 'hold' cycles, then mreq low, then RELEASE.
    task automatic finish_service(input string tag, input logic [2:0] g, input int hold);
        bus_if.mreq = 1'b1;
        bus_if.rd   = 1'b1;
        bus_if.a    = 16'hF000;
        for (int k = 0; k < hold; k++) begin
            cyc();
            check_outs($sformatf("%s.exit_hold%0d", tag, k), g, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        bus_idle();
        cyc();
        check_outs({tag, ".unmap"}, g, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        check_outs({tag, ".release"}, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req        = '0;
        n_int      = 1'b1;
        n_int_next = 1'b1;
        bus_idle();

        //   rst req   ni nin mrq m1 rd addr      | grant  nn ov bs ab
        add(1, 3'b000, 1, 1, 0, 0, 0, 16'h0000,   3'b000, 1, 0, 0, 0);
        add(0, 3'b000, 1, 0, 0, 0, 0, 16'h0000,   3'b000, 1, 0, 0, 0);
        add(0, 3'b010, 1, 1, 0, 0, 0, 16'h0000,   3'b000, 1, 0, 0, 0);
        add(0, 3'b000, 1, 1, 0, 0, 0, 16'h0000,   3'b000, 1, 0, 1, 0);
        add(0, 3'b000, 1, 1, 1, 1, 0, 16'h0066,   3'b000, 1, 0, 1, 0);
        add(0, 3'b000, 1, 0, 0, 0, 0, 16'h0000,   3'b010, 0, 0, 1, 0);
        add(0, 3'b000, 1, 1, 1, 1, 0, 16'h0067,   3'b010, 0, 0, 1, 0);
        add(0, 3'b000, 1, 1, 1, 1, 0, 16'h0066,   3'b010, 1, 1, 1, 0);
        add(0, 3'b000, 1, 1, 0, 0, 0, 16'h0000,   3'b010, 1, 1, 1, 0);
        add(0, 3'b000, 1, 1, 1, 0, 1, 16'hF001,   3'b010, 1, 1, 1, 0);
        add(0, 3'b000, 1, 1, 1, 0, 0, 16'hF000,   3'b010, 1, 1, 1, 0);
        add(0, 3'b000, 1, 1, 1, 0, 1, 16'hF000,   3'b010, 1, 1, 1, 0);
        add(0, 3'b000, 1, 1, 1, 0, 1, 16'hF000,   3'b010, 1, 1, 1, 0);
        add(0, 3'b000, 1, 1, 0, 0, 0, 16'h0000,   3'b010, 1, 0, 1, 0);
        add(0, 3'b000, 1, 1, 0, 0, 0, 16'h0000,   3'b000, 1, 0, 0, 0);
        add(0, 3'b000, 1, 0, 0, 0, 0, 16'h0000,   3'b000, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            req         = vecs[i].req;
            n_int       = vecs[i].n_int;
            n_int_next  = vecs[i].n_int_next;
            bus_if.mreq = vecs[i].mreq;
            bus_if.m1   = vecs[i].m1;
            bus_if.rd   = vecs[i].rd;
            bus_if.a    = vecs[i].a;
            cyc();
            check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].n_nmi,
                       vecs[i].ovl, vecs[i].busy, vecs[i].abort);
        end

        // Simultaneous req[2]/req[0], INT edge 100 clk after the request.
        do_reset();
        pulse_req(3'b101);
        cyc();
        repeat (98) cyc();
        check_outs("prio.wait", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        int_fall();
        check_outs("prio.first", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch66();
        check_outs("prio.map0", 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
        finish_service("prio.s0", 3'b001, 1);
        cyc();
        check_outs("prio.wait2", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        int_fall();
        check_outs("prio.second", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch66();
        finish_service("prio.s2", 3'b100, 1);
        cyc();
        check_outs("prio.idle", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Exit read with mreq held three cycles.
        do_reset();
        pulse_req(3'b010);
        cyc();
        int_fall();
        fetch66();
        finish_service("hold3", 3'b010, 3);

        // Timeout after four INT edges; the dropped request is not served again.
        do_reset();
        pulse_req(3'b011);
        cyc();
        int_fall();
        check_outs("tmo.grant", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            int_fall();
            check_outs($sformatf("tmo.frame%0d", k), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc();
        int_fall();
        check_outs("tmo.abort", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        check_outs("tmo.after", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        int_fall();
        check_outs("tmo.next", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch66();
        finish_service("tmo.s1", 3'b010, 1);
        repeat (3) cyc();
        int_fall();
        cyc();
        check_outs("tmo.dropped", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fetch on the same cycle as the timeout edge wins.
        do_reset();
        pulse_req(3'b100);
        cyc();
        int_fall();
        for (int k = 0; k < 3; k++) begin
            cyc();
            int_fall();
        end
        n_int_next  = 1'b0;
        bus_if.mreq = 1'b1;
        bus_if.m1   = 1'b1;
        bus_if.a    = 16'h0066;
        cyc();
        n_int_next = 1'b1;
        bus_idle();
        check_outs("race.fetch", 3'b100, 1'b1, 1'b1, 1'b1, 1'b0);
        finish_service("race.s", 3'b100, 1);

        // Re-request during MAPPED stays pending until after RELEASE.
        do_reset();
        pulse_req(3'b001);
        cyc();
        int_fall();
        fetch66();
        pulse_req(3'b001);
        check_outs("rereq.mapped", 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
        int_fall();
        check_outs("rereq.int", 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
        finish_service("rereq.s", 3'b001, 1);
        cyc();
        check_outs("rereq.wait", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        int_fall();
        check_outs("rereq.second", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset while mapped with mreq high.
        do_reset();
        pulse_req(3'b100);
        cyc();
        int_fall();
        fetch66();
        bus_if.mreq = 1'b1;
        bus_if.a    = 16'h1234;
        pulse_req(3'b011);
        check_outs("rst.mapped", 3'b100, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        check_outs("rst.now", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        bus_idle();
        repeat (3) cyc();
        int_fall();
        cyc();
        check_outs("rst.nopend", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
